// File: rtl/lock_key_loader_pkg.sv
`default_nettype none
// ============================================================================
// lock_key_pkg : shared widths, key-field offsets and FSM state encoding
// Revision     : 1.0
// ============================================================================
package lock_key_pkg;

  localparam int KEY_W       = 43;
  localparam int MUX_KEY_LSB = 0;
  localparam int MUX_KEY_W   = 4;
  localparam int XOR_KEY_LSB = 4;
  localparam int XOR_KEY_W   = 39;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    CHECK  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lock_key_loader_shadow.sv
`default_nettype none
// ============================================================================
// key_shadow_reg : indexed bit-write shadow register with running parity
// Revision       : 1.0
// ============================================================================
module key_shadow_reg #(
  parameter int KEY_W = 43,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             bit_we_i,
  input  logic             par_we_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             acc_o
);

  logic [KEY_W-1:0] shadow_d, shadow_q;
  logic             acc_d, acc_q;

  // Clear wins over a same-cycle write so an aborted transfer leaves no trace.
  always_comb begin
    shadow_d = shadow_q;
    acc_d    = acc_q;
    if (clr_i) begin
      shadow_d = '0;
      acc_d    = 1'b0;
    end else begin
      if (bit_we_i) begin
        shadow_d[idx_i] = bit_i;
      end
      if (bit_we_i || par_we_i) begin
        acc_d = acc_q ^ bit_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      acc_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
    end
  end

  assign shadow_o = shadow_q;
  assign acc_o    = acc_q;

endmodule
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// lock_key_loader : serial even-parity key loader with atomic key commit
// Revision        : 1.0
// ============================================================================
module lock_key_loader #(
  parameter int KEY_W = 43,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic             kbit_i,
  input  logic             kvalid_i,
  output logic             kready_o,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  import lock_key_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [KEY_W-1:0] key_d, key_q;
  logic             key_valid_d, key_valid_q;
  logic             kready_d, kready_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             err_d, err_q;

  logic             xfer;
  logic             clr;
  logic             bit_we;
  logic             par_we;
  logic [KEY_W-1:0] shadow;
  logic             acc;

  key_shadow_reg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .bit_we_i (bit_we),
    .par_we_i (par_we),
    .idx_i    (cnt_q),
    .bit_i    (kbit_i),
    .shadow_o (shadow),
    .acc_o    (acc)
  );

  assign xfer = kvalid_i && kready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    clr         = 1'b0;
    bit_we      = 1'b0;
    par_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (load_start_i) begin
          cnt_d = '0;
          clr   = 1'b1;
        end else if (xfer) begin
          bit_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (load_start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          clr     = 1'b1;
        end else if (xfer) begin
          par_we  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Start requests are ignored here; the committed key only moves on success.
        state_d = IDLE;
        if (!acc) begin
          key_d       = shadow;
          key_valid_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    kready_d = (state_d == SHIFT) || (state_d == PARITY);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      kready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      kready_q    <= kready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign kready_o    = kready_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
// tb_lock_key_loader : scoreboard bench for lock_key_loader
// Revision           : 1.0
// ============================================================================
module tb_lock_key_loader;

  localparam int KEY_W = 43;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_start_i = 1'b0;
  logic             kbit_i = 1'b0;
  logic             kvalid_i = 1'b0;
  logic             kready_o;
  logic [KEY_W-1:0] key_o;
  logic             key_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  lock_key_loader #(.KEY_W(KEY_W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .kbit_i       (kbit_i),
    .kvalid_i     (kvalid_i),
    .kready_o     (kready_o),
    .key_o        (key_o),
    .key_valid_o  (key_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_done;
    logic [KEY_W-1:0] key;
    bit               valid;
    int               cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               compared = 0;
  int               mismatched = 0;
  int               cyc = 0;
  logic             rst_edge = 1'b1;
  logic [KEY_W-1:0] model_key = '0;
  bit               model_valid = 1'b0;
  logic [KEY_W-1:0] mon_key = '0;
  bit               mon_valid = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT reports a load outcome.
  always @(negedge clk) begin
    exp_t e;
    if (rst_edge) begin
      mon_key   = '0;
      mon_valid = 1'b0;
    end else if (done_o || err_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_outcome", {62'd0, done_o, err_o}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("outcome_done_err", {62'd0, done_o, err_o}, {62'd0, e.is_done, !e.is_done});
        check("outcome_key", 64'(key_o), 64'(e.key));
        check("outcome_key_valid", 64'(key_valid_o), 64'(e.valid));
        check("outcome_cycle", 64'(cyc), 64'(e.cyc));
        mon_key   = e.key;
        mon_valid = e.valid;
      end
    end else begin
      check("key_hold", 64'(key_o), 64'(mon_key));
      check("key_valid_hold", 64'(key_valid_o), 64'(mon_valid));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_start_i = 1'b0; kvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    model_key = '0;
    model_valid = 1'b0;
    check("rst_key", 64'(key_o), 64'd0);
    check("rst_key_valid", 64'(key_valid_o), 64'd0);
    check("rst_kready", 64'(kready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
  endtask

  // Full load: optional stall before bit stall_at, optional restart at bit abort_at.
  task automatic do_load(input logic [KEY_W-1:0] key, input logic par, input int stall_at,
                         input int stall_len, input int abort_at, input bit ls_in_check);
    int   s_cyc;
    int   stalls;
    int   i;
    int   waits;
    bit   hs;
    bit   aborted;
    exp_t e;
    @(negedge clk);
    load_start_i = 1'b1; kvalid_i = 1'b0;
    s_cyc = cyc + 1;
    @(negedge clk);
    load_start_i = 1'b0;
    stalls = 0; aborted = 1'b0; i = 0; waits = 0;
    while (i <= KEY_W) begin
      if (!aborted && i == abort_at) begin
        load_start_i = 1'b1; kvalid_i = 1'b1; kbit_i = 1'($urandom);
        s_cyc = cyc + 1; aborted = 1'b1; i = 0; stalls = 0;
        @(negedge clk);
        load_start_i = 1'b0; kvalid_i = 1'b0;
        continue;
      end
      if (i == stall_at && stalls == 0 && stall_len > 0) begin
        kvalid_i = 1'b0; kbit_i = 1'($urandom);
        repeat (stall_len) @(negedge clk);
        stalls = stall_len;
      end
      kbit_i = (i < KEY_W) ? key[i] : par;
      kvalid_i = 1'b1;
      hs = kready_o;
      if (hs && i == KEY_W) begin
        e.is_done = ((^key) ^ par) == 1'b0;
        if (e.is_done) begin
          model_key = key;
          model_valid = 1'b1;
        end
        e.key = model_key;
        e.valid = model_valid;
        e.cyc = s_cyc + KEY_W + 2 + stalls;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (hs) begin
        i++;
        waits = 0;
      end else begin
        waits++;
        if (waits > 8) begin
          check("kready_timeout", 64'(kready_o), 64'd1);
          kvalid_i = 1'b0;
          return;
        end
      end
    end
    kvalid_i = 1'b0;
    if (ls_in_check) begin
      load_start_i = 1'b1;
      @(negedge clk);
      load_start_i = 1'b0;
      check("check_start_busy", 64'(busy_o), 64'd0);
      check("check_start_kready", 64'(kready_o), 64'd0);
      repeat (3) @(negedge clk);
      check("check_start_idle", 64'(busy_o), 64'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] k;
    logic             p;
    int               abort_at;
    int               stall_at;
    int               stall_len;
    repeat (3) @(negedge clk);
    do_reset();

    do_load(43'h5_A5A5_A5A5_A5, 1'b0, -1, 0, -1, 1'b0);
    do_reset();
    do_load(43'h5_A5A5_A5A5_A5, 1'b1, -1, 0, -1, 1'b0);
    do_load(43'h1, 1'b1, -1, 0, -1, 1'b0);
    do_load(43'h5_A5A5_A5A5_A5, 1'b0, 20, 10, -1, 1'b0);
    do_load(43'h7FF, 1'b1, -1, 0, -1, 1'b0);
    do_load(43'h3, 1'b0, -1, 0, 30, 1'b0);

    // Reset in the middle of a load wipes the committed key too.
    do_load(43'h7FF, 1'b1, -1, 0, -1, 1'b0);
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    for (int b = 0; b < 10; b++) begin
      kvalid_i = 1'b1; kbit_i = 1'($urandom);
      @(negedge clk);
    end
    do_reset();

    do_load(43'h0_1234_5678_9A, 1'b1, -1, 0, -1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      k = {11'($urandom), $urandom};
      p = ($urandom_range(0, 9) < 7) ? ^k : ~(^k);
      abort_at  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, KEY_W)) : -1;
      stall_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, KEY_W)) : -1;
      stall_len = int'($urandom_range(1, 6));
      do_load(k, p, stall_at, stall_len, abort_at, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
